sdram_burst_master: RTL and testbench

Request-side client for the `de10_lite_sdram` user port. It accepts multi-burst read or write jobs over a valid/ready handshake and issues one command per burst. For writes it stages each burst from a write-data stream before commanding the controller; for reads it forwards each returned beat to a read-data stream. It sits between compute/DMA logic (weight and image loaders) and the SDRAM controller, so no other block has to sequence controller commands.

---
 rtl/sdram_burst_master.sv | 260 ++++++++++++++++++++++++++
 tb/tb_sdram_burst_master.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_burst_master.sv
// Request-side client for the de10_lite_sdram user port: splits a job into
// bursts, stages write bursts from a stream and forwards read beats.
module sdram_burst_master #(
    parameter int BurstLength = 8,
    parameter int AddrWidth   = 25,
    parameter int DataWidth   = 16,
    parameter int CountBits   = 16,
    parameter int GapCycles   = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic                 req_write_i,
    input  logic [AddrWidth-1:0] req_address_i,
    input  logic [CountBits-1:0] req_bursts_i,
    input  logic [DataWidth-1:0] wr_data_i,
    input  logic                 wr_valid_i,
    output logic                 wr_ready_o,
    output logic [DataWidth-1:0] rd_data_o,
    output logic                 rd_valid_o,
    output logic                 done_o,
    output logic [1:0]           mem_command_o,
    output logic [AddrWidth-1:0] mem_address_o,
    output logic [DataWidth-1:0] mem_write_data_o,
    input  logic [DataWidth-1:0] mem_read_data_i,
    input  logic                 mem_read_valid_i,
    input  logic                 mem_write_done_i
);
    localparam int IdxW = (BurstLength > 1) ? $clog2(BurstLength) : 1;
    localparam int CntW = $clog2(BurstLength + 1);
    localparam int GapW = (GapCycles > 1) ? $clog2(GapCycles) : 1;

    localparam logic [3:0] IDLE    = 4'd0;
    localparam logic [3:0] FILL    = 4'd1;
    localparam logic [3:0] WR_CMD  = 4'd2;
    localparam logic [3:0] WR_WAIT = 4'd3;
    localparam logic [3:0] WR_DATA = 4'd4;
    localparam logic [3:0] RD_CMD  = 4'd5;
    localparam logic [3:0] RD_WAIT = 4'd6;
    localparam logic [3:0] GAP     = 4'd7;
    localparam logic [3:0] DONE    = 4'd8;

    localparam logic [1:0] CMD_IDLE  = 2'b00;
    localparam logic [1:0] CMD_WRITE = 2'b01;
    localparam logic [1:0] CMD_READ  = 2'b10;

    logic [3:0]           state_q, state_d;
    logic                 write_q, write_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [CountBits-1:0] bursts_q, bursts_d;
    logic [CountBits-1:0] k_q, k_d;
    logic [CntW-1:0]      fill_cnt_q, fill_cnt_d;
    logic [IdxW-1:0]      word_idx_q, word_idx_d;
    logic [CntW-1:0]      beat_cnt_q, beat_cnt_d;
    logic [GapW-1:0]      gap_cnt_q, gap_cnt_d;
    logic [DataWidth-1:0] buf_q [BurstLength];
    logic [DataWidth-1:0] buf_d [BurstLength];

    logic                 req_ready_q, req_ready_d;
    logic                 wr_ready_q, wr_ready_d;
    logic [DataWidth-1:0] rd_data_q, rd_data_d;
    logic                 rd_valid_q, rd_valid_d;
    logic                 done_q, done_d;
    logic [1:0]           mem_command_q, mem_command_d;
    logic [AddrWidth-1:0] mem_address_q, mem_address_d;
    logic [DataWidth-1:0] mem_write_data_q, mem_write_data_d;

    logic                 pop;
    logic [IdxW-1:0]      next_idx;
    logic [AddrWidth-1:0] next_addr;
    logic [CountBits-1:0] next_k;

    // NOTE: every always_comb output is defaulted first so no path infers a latch.
    always_comb begin
        state_d          = state_q;
        write_d          = write_q;
        addr_d           = addr_q;
        bursts_d         = bursts_q;
        k_d              = k_q;
        fill_cnt_d       = fill_cnt_q;
        word_idx_d       = word_idx_q;
        beat_cnt_d       = beat_cnt_q;
        gap_cnt_d        = gap_cnt_q;
        buf_d            = buf_q;
        mem_command_d    = CMD_IDLE;
        mem_address_d    = mem_address_q;
        mem_write_data_d = mem_write_data_q;
        rd_data_d        = rd_data_q;
        rd_valid_d       = 1'b0;

        next_idx  = word_idx_q + 1'b1;
        next_addr = addr_q + AddrWidth'(BurstLength);
        next_k    = k_q + 1'b1;
        pop       = (state_q == FILL) && wr_valid_i && wr_ready_q;

        case (state_q)
            IDLE: begin
                if (req_valid_i && req_ready_q) begin
                    write_d  = req_write_i;
                    addr_d   = req_address_i;
                    bursts_d = req_bursts_i;
                    k_d      = '0;
                    if (req_bursts_i == '0) begin
                        state_d = DONE;
                    end else if (req_write_i) begin
                        state_d    = FILL;
                        fill_cnt_d = '0;
                    end else begin
                        state_d       = RD_CMD;
                        beat_cnt_d    = '0;
                        mem_command_d = CMD_READ;
                        mem_address_d = req_address_i;
                    end
                end
            end
            FILL: begin
                if (pop) begin
                    buf_d[fill_cnt_q[IdxW-1:0]] = wr_data_i;
                    fill_cnt_d = fill_cnt_q + 1'b1;
                    if (fill_cnt_q == CntW'(BurstLength - 1)) begin
                        // buf_d so that word 0 is correct even when it is the word just popped
                        state_d          = WR_CMD;
                        word_idx_d       = '0;
                        mem_command_d    = CMD_WRITE;
                        mem_address_d    = addr_q;
                        mem_write_data_d = buf_d[0];
                    end
                end
            end
            WR_CMD: begin
                state_d = WR_WAIT;
            end
            WR_WAIT: begin
                if (mem_write_done_i) begin
                    if (BurstLength == 1) begin
                        state_d   = GAP;
                        gap_cnt_d = '0;
                    end else begin
                        state_d          = WR_DATA;
                        word_idx_d       = next_idx;
                        mem_write_data_d = buf_q[next_idx];
                    end
                end
            end
            WR_DATA: begin
                if (word_idx_q == IdxW'(BurstLength - 1)) begin
                    state_d   = GAP;
                    gap_cnt_d = '0;
                end else begin
                    word_idx_d       = next_idx;
                    mem_write_data_d = buf_q[next_idx];
                end
            end
            RD_CMD: begin
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (mem_read_valid_i) begin
                    rd_valid_d = 1'b1;
                    rd_data_d  = mem_read_data_i;
                    if (beat_cnt_q == CntW'(BurstLength - 1)) begin
                        state_d   = GAP;
                        gap_cnt_d = '0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            GAP: begin
                if (gap_cnt_q == GapW'(GapCycles - 1)) begin
                    k_d    = next_k;
                    addr_d = next_addr;
                    if (next_k < bursts_q) begin
                        if (write_q) begin
                            state_d    = FILL;
                            fill_cnt_d = '0;
                        end else begin
                            state_d       = RD_CMD;
                            beat_cnt_d    = '0;
                            mem_command_d = CMD_READ;
                            mem_address_d = next_addr;
                        end
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Status outputs are registered copies of what the next state implies.
        done_d      = (state_d == DONE);
        req_ready_d = (state_d == IDLE);
        wr_ready_d  = (state_d == FILL) && (fill_cnt_d != CntW'(BurstLength));
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q          <= IDLE;
            write_q          <= 1'b0;
            addr_q           <= '0;
            bursts_q         <= '0;
            k_q              <= '0;
            fill_cnt_q       <= '0;
            word_idx_q       <= '0;
            beat_cnt_q       <= '0;
            gap_cnt_q        <= '0;
            req_ready_q      <= 1'b0;
            wr_ready_q       <= 1'b0;
            rd_data_q        <= '0;
            rd_valid_q       <= 1'b0;
            done_q           <= 1'b0;
            mem_command_q    <= CMD_IDLE;
            mem_address_q    <= '0;
            mem_write_data_q <= '0;
        end else begin
            state_q          <= state_d;
            write_q          <= write_d;
            addr_q           <= addr_d;
            bursts_q         <= bursts_d;
            k_q              <= k_d;
            fill_cnt_q       <= fill_cnt_d;
            word_idx_q       <= word_idx_d;
            beat_cnt_q       <= beat_cnt_d;
            gap_cnt_q        <= gap_cnt_d;
            req_ready_q      <= req_ready_d;
            wr_ready_q       <= wr_ready_d;
            rd_data_q        <= rd_data_d;
            rd_valid_q       <= rd_valid_d;
            done_q           <= done_d;
            mem_command_q    <= mem_command_d;
            mem_address_q    <= mem_address_d;
            mem_write_data_q <= mem_write_data_d;
        end
    end

    // NOTE: the staging buffer is not reset; fill_cnt_q alone says which words are valid.
    always_ff @(posedge clk_i) begin
        buf_q <= buf_d;
    end

    assign req_ready_o      = req_ready_q;
    assign wr_ready_o       = wr_ready_q;
    assign rd_data_o        = rd_data_q;
    assign rd_valid_o       = rd_valid_q;
    assign done_o           = done_q;
    assign mem_command_o    = mem_command_q;
    assign mem_address_o    = mem_address_q;
    assign mem_write_data_o = mem_write_data_q;

endmodule

// File: tb/tb_sdram_burst_master.sv
// Scoreboard bench for sdram_burst_master with a simple SDRAM controller model
// that acknowledges writes, stores them and returns read bursts.
module tb_sdram_burst_master;
    localparam int BL = 8;
    localparam int AW = 25;
    localparam int DW = 16;
    localparam int CB = 16;

    typedef struct {
        logic [1:0]    cmd;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          chk_data;
    } exp_cmd_t;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          req_valid_i;
    logic          req_ready_o;
    logic          req_write_i;
    logic [AW-1:0] req_address_i;
    logic [CB-1:0] req_bursts_i;
    logic [DW-1:0] wr_data_i;
    logic          wr_valid_i;
    logic          wr_ready_o;
    logic [DW-1:0] rd_data_o;
    logic          rd_valid_o;
    logic          done_o;
    logic [1:0]    mem_command_o;
    logic [AW-1:0] mem_address_o;
    logic [DW-1:0] mem_write_data_o;
    logic [DW-1:0] mem_read_data_i;
    logic          mem_read_valid_i;
    logic          mem_write_done_i;

    exp_cmd_t      exp_cmd_q[$];
    logic [DW-1:0] exp_rd_q[$];
    logic [DW-1:0] exp_wr_q[$];
    int            exp_done_cnt = 0;
    int            checks = 0;
    int            failures = 0;
    int            pops_total = 0;
    int            n_wcmd = 0;
    int            rd_seen = 0;
    logic [DW-1:0] mem [int];

    int            rd_lat, rd_beat, wr_lat, wr_idx;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [1:0]    prev_cmd;
    exp_cmd_t      mon_e;

    always #5 clk = ~clk;

    sdram_burst_master dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .req_valid_i      (req_valid_i),
        .req_ready_o      (req_ready_o),
        .req_write_i      (req_write_i),
        .req_address_i    (req_address_i),
        .req_bursts_i     (req_bursts_i),
        .wr_data_i        (wr_data_i),
        .wr_valid_i       (wr_valid_i),
        .wr_ready_o       (wr_ready_o),
        .rd_data_o        (rd_data_o),
        .rd_valid_o       (rd_valid_o),
        .done_o           (done_o),
        .mem_command_o    (mem_command_o),
        .mem_address_o    (mem_address_o),
        .mem_write_data_o (mem_write_data_o),
        .mem_read_data_i  (mem_read_data_i),
        .mem_read_valid_i (mem_read_valid_i),
        .mem_write_done_i (mem_write_done_i)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic expect_write_burst(input logic [AW-1:0] addr, input logic [DW-1:0] first);
        exp_cmd_t e;
        e.cmd = 2'b01; e.addr = addr; e.data = first; e.chk_data = 1'b1;
        exp_cmd_q.push_back(e);
        for (int w = 0; w < BL; w++) exp_wr_q.push_back(first + DW'(w));
    endtask

    task automatic expect_read_burst(input logic [AW-1:0] addr, input logic [DW-1:0] first);
        exp_cmd_t e;
        e.cmd = 2'b10; e.addr = addr; e.data = '0; e.chk_data = 1'b0;
        exp_cmd_q.push_back(e);
        for (int w = 0; w < BL; w++) exp_rd_q.push_back(first + DW'(w));
    endtask

    // Returns at the negedge one cycle after the accepting edge.
    task automatic issue_job(input logic wr, input logic [AW-1:0] addr, input logic [CB-1:0] bursts);
        int t;
        t = 0;
        @(negedge clk);
        req_valid_i = 1'b1; req_write_i = wr; req_address_i = addr; req_bursts_i = bursts;
        while (!req_ready_o && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready_o) check("req_accept_timeout", req_ready_o, 1'b1);
        @(negedge clk);
        req_valid_i = 1'b0;
    endtask

    task automatic stream_words(input int n, input logic [DW-1:0] first, input int stall_at, input int stall_len);
        int   i, stalled, t;
        logic rdy_prev;
        i = 0; stalled = 0; t = 0; rdy_prev = 1'b0;
        while (i < n && t < 2000) begin
            @(negedge clk);
            t++;
            if (wr_valid_i && rdy_prev) begin
                i++;
                pops_total++;
            end
            if (i < n && !(i == stall_at && stalled < stall_len)) begin
                wr_valid_i = 1'b1;
                wr_data_i  = first + DW'(i);
            end else begin
                wr_valid_i = 1'b0;
                if (i == stall_at) stalled++;
            end
            rdy_prev = wr_ready_o;
        end
        wr_valid_i = 1'b0;
        if (i < n) check("wr_stream_timeout", i, n);
    endtask

    task automatic wait_jobs(input string name);
        int t;
        t = 0;
        while (exp_done_cnt > 0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check(name, exp_done_cnt, 0);
    endtask

    task automatic capture_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
        mem[int'(a)] = d;
        if (exp_wr_q.size() == 0) check("wr_unexpected", exp_wr_q.size(), 1);
        else check("wr_data", d, exp_wr_q.pop_front());
    endtask

    // Controller model: write_done two cycles after a write command, read beats
    // starting two cycles after a read command.
    initial begin
        rd_lat = -1; rd_beat = -1; wr_lat = -1; wr_idx = -1;
        rd_addr = '0; wr_addr = '0;
        mem_read_valid_i = 1'b0; mem_write_done_i = 1'b0; mem_read_data_i = '0;
        forever begin
            @(negedge clk);
            mem_read_valid_i = 1'b0;
            mem_write_done_i = 1'b0;
            if (rst_i) begin
                rd_lat = -1; rd_beat = -1; wr_lat = -1; wr_idx = -1;
            end else begin
                if (wr_idx >= 1) begin
                    capture_word(wr_addr + AW'(wr_idx), mem_write_data_o);
                    wr_idx++;
                    if (wr_idx == BL) wr_idx = -1;
                end
                if (wr_lat > 0) begin
                    wr_lat--;
                    if (wr_lat == 0) begin
                        mem_write_done_i = 1'b1;
                        capture_word(wr_addr, mem_write_data_o);
                        wr_idx = (BL > 1) ? 1 : -1;
                        wr_lat = -1;
                    end
                end
                if (rd_lat > 0) begin
                    rd_lat--;
                    if (rd_lat == 0) begin
                        rd_beat = 0;
                        rd_lat  = -1;
                    end
                end
                if (rd_beat >= 0) begin
                    mem_read_valid_i = 1'b1;
                    mem_read_data_i  = mem.exists(int'(rd_addr + AW'(rd_beat)))
                                       ? mem[int'(rd_addr + AW'(rd_beat))] : '0;
                    rd_beat++;
                    if (rd_beat == BL) rd_beat = -1;
                end
                if (mem_command_o == 2'b01) begin
                    wr_lat = 2; wr_addr = mem_address_o;
                end else if (mem_command_o == 2'b10) begin
                    rd_lat = 2; rd_addr = mem_address_o;
                end
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a command, beat or done.
    initial begin
        prev_cmd = 2'b00;
        forever begin
            @(negedge clk);
            #1;
            if (rst_i) begin
                prev_cmd = 2'b00;
            end else begin
                if (mem_command_o != 2'b00) begin
                    check("cmd_spacing", prev_cmd, 2'b00);
                    if (exp_cmd_q.size() == 0) begin
                        check("cmd_unexpected", mem_command_o, 2'b00);
                    end else begin
                        mon_e = exp_cmd_q.pop_front();
                        check("cmd_type", mem_command_o, mon_e.cmd);
                        check("cmd_addr", mem_address_o, mon_e.addr);
                        if (mon_e.chk_data) check("cmd_wdata0", mem_write_data_o, mon_e.data);
                        if (mem_command_o == 2'b01) begin
                            n_wcmd++;
                            check("wr_cmd_after_fill", pops_total, n_wcmd * BL);
                        end
                    end
                end
                prev_cmd = mem_command_o;
                if (rd_valid_o) begin
                    rd_seen++;
                    if (exp_rd_q.size() == 0) check("rd_unexpected", rd_valid_o, 1'b0);
                    else check("rd_data", rd_data_o, exp_rd_q.pop_front());
                end
                if (done_o) begin
                    if (exp_done_cnt == 0) check("done_unexpected", done_o, 1'b0);
                    else exp_done_cnt--;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        int t;
        rst_i = 1'b1; req_valid_i = 1'b0; req_write_i = 1'b0; req_address_i = '0;
        req_bursts_i = '0; wr_data_i = '0; wr_valid_i = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_req_ready", req_ready_o, 1'b0);
        check("rst_mem_command", mem_command_o, 2'b00);
        check("rst_mem_address", mem_address_o, '0);
        check("rst_mem_wdata", mem_write_data_o, '0);
        check("rst_rd_valid", rd_valid_o, 1'b0);
        check("rst_rd_data", rd_data_o, '0);
        check("rst_wr_ready", wr_ready_o, 1'b0);
        check("rst_done", done_o, 1'b0);
        rst_i = 1'b0;
        @(negedge clk);
        check("post_rst_req_ready", req_ready_o, 1'b1);

        // Single write burst.
        expect_write_burst(25'h0000100, 16'hA000);
        exp_done_cnt++;
        issue_job(1'b1, 25'h0000100, 16'd1);
        check("fill_wr_ready", wr_ready_o, 1'b1);
        stream_words(8, 16'hA000, -1, 0);
        wait_jobs("single_write_done");

        // Readback.
        expect_read_burst(25'h0000100, 16'hA000);
        exp_done_cnt++;
        issue_job(1'b0, 25'h0000100, 16'd1);
        check("rd_cmd_latency", mem_command_o, 2'b10);
        wait_jobs("readback_done");

        // Three bursts wrapping past the top of the address space.
        expect_write_burst(25'h1FFFFF8, 16'hB000);
        expect_write_burst(25'h0000000, 16'hB008);
        expect_write_burst(25'h0000008, 16'hB010);
        exp_done_cnt++;
        issue_job(1'b1, 25'h1FFFFF8, 16'd3);
        stream_words(24, 16'hB000, -1, 0);
        wait_jobs("wrap_write_done");
        expect_read_burst(25'h1FFFFF8, 16'hB000);
        expect_read_burst(25'h0000000, 16'hB008);
        expect_read_burst(25'h0000008, 16'hB010);
        exp_done_cnt++;
        issue_job(1'b0, 25'h1FFFFF8, 16'd3);
        wait_jobs("wrap_read_done");

        // Write stream with a 5-cycle hole between words 3 and 4.
        expect_write_burst(25'h0000200, 16'hC000);
        exp_done_cnt++;
        issue_job(1'b1, 25'h0000200, 16'd1);
        stream_words(8, 16'hC000, 4, 5);
        wait_jobs("stall_write_done");

        // Zero-burst job.
        exp_done_cnt++;
        issue_job(1'b0, 25'h0000300, 16'd0);
        check("zero_done_pulse", done_o, 1'b1);
        @(negedge clk);
        check("zero_done_one_cycle", done_o, 1'b0);
        check("zero_req_ready", req_ready_o, 1'b1);

        // Reset in the middle of a read burst.
        expect_read_burst(25'h0000100, 16'hA000);
        exp_done_cnt++;
        issue_job(1'b0, 25'h0000100, 16'd1);
        base = rd_seen;
        t = 0;
        while (rd_seen < base + 3 && t < 200) begin
            @(negedge clk);
            #2;
            t++;
        end
        check("mid_read_beats", rd_seen - base, 3);
        rst_i = 1'b1;
        exp_cmd_q.delete();
        exp_rd_q.delete();
        exp_wr_q.delete();
        exp_done_cnt = 0;
        @(negedge clk);
        @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);
        check("mid_rst_rd_valid", rd_valid_o, 1'b0);
        check("mid_rst_mem_command", mem_command_o, 2'b00);
        check("mid_rst_req_ready", req_ready_o, 1'b1);

        // New read after reset; also reads back the stalled write.
        expect_read_burst(25'h0000200, 16'hC000);
        exp_done_cnt++;
        issue_job(1'b0, 25'h0000200, 16'd1);
        wait_jobs("post_rst_read_done");

        repeat (4) @(negedge clk);
        check("exp_cmd_left", exp_cmd_q.size(), 0);
        check("exp_rd_left", exp_rd_q.size(), 0);
        check("exp_wr_left", exp_wr_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
